// File: rtl/ser_tx_frame.sv
// Framed serial transmitter: start bit, LSB-first data, optional parity, one or two stop bits.
// Every bit is held for BAUD_DIV+1 clocks; a word is accepted over a VALID/READY handshake.
module ser_tx_frame #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VALID,
  output logic              READY,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [1:0]        PARITY_MODE,
  input  logic              STOP2,
  input  logic [DIV_W-1:0]  BAUD_DIV,
  output logic              TXD,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               par_bit_q, par_bit_d;
  logic               par_en_q, par_en_d;
  logic               stop2_q, stop2_d;
  logic [DIV_W-1:0]   div_lim_q, div_lim_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               txd_q, txd_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               bit_end;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      div_lim_q <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      div_lim_q <= div_lim_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; TXD is computed one cycle ahead so the line itself is a flop.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    div_lim_d = div_lim_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_end   = (div_cnt_q == div_lim_q);

    // Divider wraps at the latched limit, so an all-ones limit never overflows.
    if (state_q != S_IDLE) begin
      div_cnt_d = bit_end ? '0 : div_cnt_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (VALID) begin
          data_d    = DATA_IN;
          par_en_d  = (PARITY_MODE == 2'b01) || (PARITY_MODE == 2'b10);
          par_bit_d = (PARITY_MODE == 2'b01) ? ~^DATA_IN : ^DATA_IN;
          stop2_d   = STOP2;
          div_lim_d = BAUD_DIV;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          txd_d     = 1'b0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          txd_d     = data_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (par_en_q) begin
              txd_d   = par_bit_q;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            // Shift register keeps the current bit at position 0.
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            data_d    = data_q >> 1;
            txd_d     = data_d[0];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          txd_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = CNT_W'(1);
          end else begin
            bit_cnt_d = '0;
            txd_d     = 1'b1;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      default: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign TXD   = txd_q;
  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_ser_tx_frame.sv
// Bench for ser_tx_frame: an 8-bit and a 12-bit instance checked cycle by cycle against
// a frame model built from a list of expected line bits.
module tb_ser_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid0, ready0, stop2_0, txd0, busy0, done0;
  logic [7:0]  data0, div0;
  logic [1:0]  mode0;
  logic        valid1, ready1, stop2_1, txd1, busy1, done1;
  logic [11:0] data1;
  logic [7:0]  div1;
  logic [1:0]  mode1;

  int errors = 0;
  int checks = 0;
  bit exp_bits[$];

  ser_tx_frame #(.DATA_W(8), .DIV_W(8)) u_dut8 (
    .CLK(clk), .RST(rst), .VALID(valid0), .READY(ready0), .DATA_IN(data0),
    .PARITY_MODE(mode0), .STOP2(stop2_0), .BAUD_DIV(div0),
    .TXD(txd0), .BUSY(busy0), .DONE(done0)
  );

  ser_tx_frame #(.DATA_W(12), .DIV_W(8)) u_dut12 (
    .CLK(clk), .RST(rst), .VALID(valid1), .READY(ready1), .DATA_IN(data1),
    .PARITY_MODE(mode1), .STOP2(stop2_1), .BAUD_DIV(div1),
    .TXD(txd1), .BUSY(busy1), .DONE(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {txd, ready, busy, done}
  function automatic logic [3:0] obs(input int inst);
    if (inst == 0) return {txd0, ready0, busy0, done0};
    return {txd1, ready1, busy1, done1};
  endfunction

  task automatic drive(input int inst, input logic v, input logic [15:0] d,
                       input logic [1:0] m, input logic s2, input logic [7:0] dv);
    if (inst == 0) begin
      valid0 = v; data0 = d[7:0]; mode0 = m; stop2_0 = s2; div0 = dv;
    end else begin
      valid1 = v; data1 = d[11:0]; mode1 = m; stop2_1 = s2; div1 = dv;
    end
  endtask

  // Line bits of one frame, derived from the frame format and a ones count.
  task automatic build_frame(input int w, input logic [15:0] d, input logic [1:0] m, input logic s2);
    int ones;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (m == 2'b01) exp_bits.push_back((ones % 2) == 0);
    else if (m == 2'b10) exp_bits.push_back((ones % 2) == 1);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the DONE edge.
  task automatic send_frame(input int inst, input logic [15:0] d, input logic [1:0] m,
                            input logic s2, input logic [7:0] dv, input bit b2b,
                            input logic [15:0] nd, input logic [1:0] nm, input logic ns2,
                            input logic [7:0] ndv, input string name);
    int per, len;
    logic [3:0] o;
    build_frame((inst == 0) ? 8 : 12, d, m, s2);
    per = int'(dv) + 1;
    len = exp_bits.size() * per;
    drive(inst, 1'b1, d, m, s2, dv);
    o = obs(inst);
    chk($sformatf("%s ready_pre", name), o[2], 1);
    @(posedge clk);
    @(negedge clk);
    if (b2b) drive(inst, 1'b1, nd, nm, ns2, ndv);
    else drive(inst, 1'b0, 16'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
    for (int i = 0; i <= len; i++) begin
      if (i > 0) @(negedge clk);
      o = obs(inst);
      if (i < len) begin
        chk($sformatf("%s c%0d txd", name, i), o[3], exp_bits[i / per]);
        chk($sformatf("%s c%0d ready", name, i), o[2], 0);
        chk($sformatf("%s c%0d busy", name, i), o[1], 1);
        chk($sformatf("%s c%0d done", name, i), o[0], 0);
      end else begin
        chk($sformatf("%s end txd", name), o[3], 1);
        chk($sformatf("%s end ready", name), o[2], 1);
        chk($sformatf("%s end busy", name), o[1], 0);
        chk($sformatf("%s end done", name), o[0], 1);
      end
    end
  endtask

  task automatic idle_cycles(input int inst, input int n, input string name);
    logic [3:0] o;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o = obs(inst);
      chk($sformatf("%s idle%0d", name, i), 32'(o), 32'(4'b1100));
    end
  endtask

  initial begin
    logic [15:0] cd, nd;
    logic [1:0]  cm, nm;
    logic        cs, ns;
    logic [7:0]  cdv, ndv;
    bit          b2b;
    logic [3:0]  o;

    rst = 1'b1;
    drive(0, 1'b0, 16'h0, 2'b00, 1'b0, 8'h0);
    drive(1, 1'b0, 16'h0, 2'b00, 1'b0, 8'h0);
    #1;
    chk("reset dut8", 32'(obs(0)), 32'(4'b1100));
    chk("reset dut12", 32'(obs(1)), 32'(4'b1100));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(0, 2, "post_reset");

    send_frame(0, 16'hA5, 2'b00, 1'b0, 8'd0, 1'b0, 0, 0, 0, 0, "a5_plain");
    idle_cycles(0, 1, "a5_after");
    send_frame(0, 16'h07, 2'b01, 1'b0, 8'd3, 1'b0, 0, 0, 0, 0, "07_odd");
    send_frame(0, 16'h07, 2'b10, 1'b0, 8'd3, 1'b0, 0, 0, 0, 0, "07_even");
    idle_cycles(0, 2, "07_after");
    send_frame(0, 16'h00, 2'b10, 1'b1, 8'd1, 1'b0, 0, 0, 0, 0, "00_even_2stop");
    send_frame(0, 16'h00, 2'b11, 1'b1, 8'd1, 1'b0, 0, 0, 0, 0, "00_mode11");
    send_frame(0, 16'h5B, 2'b11, 1'b0, 8'd0, 1'b0, 0, 0, 0, 0, "5b_mode11");

    // Back-to-back with the next word and settings applied while the first is in flight.
    send_frame(0, 16'h3C, 2'b01, 1'b0, 8'd2, 1'b1, 16'hC3, 2'b10, 1'b1, 8'd1, "b2b_3c");
    send_frame(0, 16'hC3, 2'b10, 1'b1, 8'd1, 1'b0, 0, 0, 0, 0, "b2b_c3");
    idle_cycles(0, 2, "b2b_after");

    // Reset while data bit 3 is on the line (cycles 12..14 with a 3-cycle bit).
    drive(0, 1'b1, 16'h5A, 2'b00, 1'b0, 8'd2);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 2'b00, 1'b0, 8'd0);
    repeat (13) @(negedge clk);
    o = obs(0);
    chk("pre_rst txd bit3", o[3], 1'b1);
    chk("pre_rst busy", o[1], 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst async", 32'(obs(0)), 32'(4'b1100));
    @(negedge clk);
    chk("mid_rst held", 32'(obs(0)), 32'(4'b1100));
    rst = 1'b0;
    idle_cycles(0, 3, "after_rst");
    send_frame(0, 16'h81, 2'b01, 1'b0, 8'd1, 1'b0, 0, 0, 0, 0, "81_after_rst");

    // Wide word at the slowest divider.
    send_frame(1, 16'h0ABC, 2'b00, 1'b0, 8'hFF, 1'b0, 0, 0, 0, 0, "abc_div255");
    idle_cycles(1, 1, "abc_after");
    send_frame(1, 16'h0F31, 2'b01, 1'b1, 8'd2, 1'b0, 0, 0, 0, 0, "f31_w12");

    cd  = 16'($urandom);
    cm  = 2'($urandom);
    cs  = 1'($urandom);
    cdv = 8'($urandom_range(0, 4));
    for (int n = 0; n < 25; n++) begin
      nd  = 16'($urandom);
      nm  = 2'($urandom);
      ns  = 1'($urandom);
      ndv = 8'($urandom_range(0, 4));
      b2b = 1'($urandom_range(0, 1));
      send_frame(0, cd, cm, cs, cdv, b2b, nd, nm, ns, ndv, $sformatf("rnd%0d", n));
      if (!b2b) idle_cycles(0, $urandom_range(0, 3), $sformatf("rnd%0d", n));
      cd  = nd;
      cm  = nm;
      cs  = ns;
      cdv = ndv;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
